// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: decode-side handshake and HI/LO result bus for the
// multiply/divide sequencer. The master drives requests; the slave (the
// sequencer) returns status and the HI/LO registers.
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic             sign_op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             hilo_rd;
    logic             busy;
    logic             stall;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, sign_op, rs_val, rt_val, hilo_rd,
        input  busy, stall, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, sign_op, rs_val, rt_val, hilo_rd,
        output busy, stall, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle engine for MIPS mult/multu/div/divu.
// Runs a 32-step shift-add multiply or restoring divide and writes the
// 64-bit result into HI/LO, stalling the core while a new request or an
// mfhi/mflo would see an unfinished result.
// Optional signed operation is enabled by defining MULDIV_SIGNED_EN; it adds
// a one-cycle FIX state that applies the result signs after the iterations.
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    muldiv_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
`ifdef MULDIV_SIGNED_EN
        , S_FIX = 2'd3
`endif
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [CNT_W-1:0]   r_count;
    // The multiply accumulator is conceptually {carry, upper, lower}; after
    // every right shift the carry is zero again, so only 64 bits are stored.
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_operand;
    logic [WIDTH-1:0]   r_dividend;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_isDiv;
    logic               r_divZero;
    logic               r_done;
    logic               r_dbz;

    logic               w_accept;
    logic               w_iterating;
    logic               w_lastIter;
    logic               w_goFix;
    logic               w_complete;
    logic               w_rsNeg;
    logic               w_rtNeg;
    logic [WIDTH-1:0]   w_rsMag;
    logic [WIDTH-1:0]   w_rtMag;
    logic [WIDTH:0]     w_mulSum;
    logic [2*WIDTH-1:0] w_mulNext;
    logic [2*WIDTH:0]   w_divShift;
    logic [WIDTH+1:0]   w_divTrial;
    logic [2*WIDTH-1:0] w_divNext;
    logic [2*WIDTH-1:0] w_iterNext;
    logic [WIDTH-1:0]   w_finalHi;
    logic [WIDTH-1:0]   w_finalLo;
    logic               w_unused;

    assign w_accept    = (r_state == S_IDLE) & bus.start;
    assign w_iterating = (r_state == S_MUL) | (r_state == S_DIV);
    assign w_lastIter  = w_iterating & (r_count == '1);

`ifdef MULDIV_SIGNED_EN
    logic r_signed;
    logic r_negQ;
    logic r_negR;

    assign w_rsNeg    = bus.sign_op & bus.rs_val[WIDTH-1];
    assign w_rtNeg    = bus.sign_op & bus.rt_val[WIDTH-1];
    assign w_goFix    = r_signed;
    assign w_complete = (w_lastIter & ~w_goFix) | (r_state == S_FIX);
    assign w_unused   = w_divTrial[WIDTH];

    // Record signedness and which result halves must be negated in FIX.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_signed <= 1'b0;
            r_negQ   <= 1'b0;
            r_negR   <= 1'b0;
        end else if (w_accept) begin
            r_signed <= bus.sign_op;
            r_negQ   <= w_rsNeg ^ w_rtNeg;
            r_negR   <= bus.op & w_rsNeg;
        end
    end
`else
    assign w_rsNeg    = 1'b0;
    assign w_rtNeg    = 1'b0;
    assign w_goFix    = 1'b0;
    assign w_complete = w_lastIter;
    assign w_unused   = ^{w_divTrial[WIDTH], bus.sign_op};
`endif

    assign w_rsMag = w_rsNeg ? -bus.rs_val : bus.rs_val;
    assign w_rtMag = w_rtNeg ? -bus.rt_val : bus.rt_val;

    // One shift-add step: add the multiplicand to the upper half when the
    // multiplier LSB is set, then shift the whole accumulator right.
    assign w_mulSum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                     + {1'b0, (r_acc[0] ? r_operand : {WIDTH{1'b0}})};
    assign w_mulNext = {w_mulSum, r_acc[WIDTH-1:1]};

    // One restoring-divide step: shift left, trial-subtract the divisor from
    // the 33-bit shifted remainder, keep it and set a quotient bit if >= 0.
    assign w_divShift = {r_acc, 1'b0};
    assign w_divTrial = {1'b0, w_divShift[2*WIDTH:WIDTH]} - {2'b00, r_operand};
    assign w_divNext  = w_divTrial[WIDTH+1] ? w_divShift[2*WIDTH-1:0]
                      : {w_divTrial[WIDTH-1:0], w_divShift[WIDTH-1:1], 1'b1};

    assign w_iterNext = (r_state == S_DIV) ? w_divNext : w_mulNext;

    // Select the value written into HI/LO on the completing edge, applying
    // the sign fix-up and the divide-by-zero override.
    always_comb begin
        w_finalHi = w_iterNext[2*WIDTH-1:WIDTH];
        w_finalLo = w_iterNext[WIDTH-1:0];
`ifdef MULDIV_SIGNED_EN
        if (r_state == S_FIX) begin
            if (r_isDiv) begin
                w_finalHi = r_negR ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
                w_finalLo = r_negQ ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
            end else begin
                {w_finalHi, w_finalLo} = r_negQ ? -r_acc : r_acc;
            end
        end
`endif
        if (r_isDiv && r_divZero) begin
            w_finalHi = r_dividend;
            w_finalLo = '1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // FSM next-state: IDLE launches on start, iterate 32 steps, optional FIX.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_nextState = bus.op ? S_DIV : S_MUL;
                end
            end
            S_MUL, S_DIV: begin
                if (r_count == '1) begin
`ifdef MULDIV_SIGNED_EN
                    w_nextState = r_signed ? S_FIX : S_IDLE;
`else
                    w_nextState = S_IDLE;
`endif
                end
            end
`ifdef MULDIV_SIGNED_EN
            S_FIX: w_nextState = S_IDLE;
`endif
            default: w_nextState = S_IDLE;
        endcase
    end

    // Datapath: latch operands on accept, step each cycle, commit HI/LO.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= '0;
            r_acc      <= '0;
            r_operand  <= '0;
            r_dividend <= '0;
            r_isDiv    <= 1'b0;
            r_divZero  <= 1'b0;
            r_done     <= 1'b0;
            r_dbz      <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            r_done <= w_complete;
            r_dbz  <= w_complete & r_isDiv & r_divZero;
            if (w_accept) begin
                r_count    <= '0;
                r_isDiv    <= bus.op;
                r_operand  <= bus.op ? w_rtMag : w_rsMag;
                r_acc      <= {{WIDTH{1'b0}}, (bus.op ? w_rsMag : w_rtMag)};
                r_dividend <= bus.rs_val;
                r_divZero  <= (bus.rt_val == '0);
            end else if (w_iterating) begin
                r_count <= r_count + CNT_W'(1);
                r_acc   <= w_iterNext;
            end
            if (w_complete) begin
                r_hi <= w_finalHi;
                r_lo <= w_finalLo;
            end
        end
    end

    assign bus.busy        = (r_state != S_IDLE);
    assign bus.stall       = bus.busy & (bus.start | bus.hilo_rd);
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed bench for muldiv_sequencer. A cycle-level
// arithmetic model (busy countdown plus plain * / % results) is compared
// against the DUT every cycle; directed cases also pin hand-computed values.
module tb_muldiv_sequencer;
    localparam int WIDTH = 32;
`ifdef MULDIV_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   assertCount = 0;
    int   failCount = 0;
    bit   checkEn = 1'b0;

    int          mBusyCnt = 0;
    logic [31:0] mHi = '0;
    logic [31:0] mLo = '0;
    logic        mDone = 1'b0;
    logic        mDbz = 1'b0;
    logic [31:0] pendHi = '0;
    logic [31:0] pendLo = '0;
    logic        pendDbz = 1'b0;

    muldiv_sequencer_if #(.WIDTH(WIDTH)) bus ();

    muldiv_sequencer #(.WIDTH(WIDTH), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Result of one operation straight from the arithmetic definition.
    task automatic computeExpected(input logic opIn, input logic sgnIn,
                                   input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] eHi, output logic [31:0] eLo,
                                   output logic eDbz, output int eLat);
        logic [63:0] p;
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic        effSigned;
        effSigned = sgnIn & SIGNED_BUILD;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        eDbz = 1'b0;
        eLat = 32 + int'(effSigned);
        if (!opIn) begin
            if (effSigned) p = sa * sb;
            else           p = {32'b0, a} * {32'b0, b};
            eHi = p[63:32];
            eLo = p[31:0];
        end else if (b == 32'd0) begin
            eHi  = a;
            eLo  = '1;
            eDbz = 1'b1;
        end else if (effSigned) begin
            q   = sa / sb;
            r   = sa % sb;
            eHi = r[31:0];
            eLo = q[31:0];
        end else begin
            eHi = a % b;
            eLo = a / b;
        end
    endtask

    // Reference model: idle accepts start, then counts down the latency and
    // publishes the precomputed result with a one-cycle done.
    always @(posedge clk) begin
        int lat;
        if (rst) begin
            mBusyCnt = 0; mHi = '0; mLo = '0; mDone = 1'b0; mDbz = 1'b0;
        end else begin
            mDone = 1'b0;
            mDbz  = 1'b0;
            if (mBusyCnt > 0) begin
                mBusyCnt--;
                if (mBusyCnt == 0) begin
                    mDone = 1'b1; mDbz = pendDbz; mHi = pendHi; mLo = pendLo;
                end
            end else if (bus.start) begin
                computeExpected(bus.op, bus.sign_op, bus.rs_val, bus.rt_val,
                                pendHi, pendLo, pendDbz, lat);
                mBusyCnt = lat;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(posedge clk) begin
        #1;
        if (checkEn) begin
            checkOutput("cyc_busy",  64'(bus.busy), 64'(mBusyCnt > 0));
            checkOutput("cyc_stall", 64'(bus.stall),
                        64'((mBusyCnt > 0) && (bus.start || bus.hilo_rd)));
            checkOutput("cyc_done",  64'(bus.done), 64'(mDone));
            checkOutput("cyc_dbz",   64'(bus.div_by_zero), 64'(mDbz));
            checkOutput("cyc_hi",    64'(bus.hi), 64'(mHi));
            checkOutput("cyc_lo",    64'(bus.lo), 64'(mLo));
        end
    end

    // Issue one start cycle; stall is checked while start is on the bus.
    task automatic applyStimulus(input logic opIn, input logic sgnIn,
                                 input logic [31:0] rsIn, input logic [31:0] rtIn,
                                 input logic rdIn, input logic expStall);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.op      = opIn;
        bus.sign_op = sgnIn;
        bus.rs_val  = rsIn;
        bus.rt_val  = rtIn;
        bus.hilo_rd = rdIn;
        #1 checkOutput("issue_stall", 64'(bus.stall), 64'(expStall));
        @(negedge clk);
        bus.start   = 1'b0;
        bus.hilo_rd = 1'b0;
    endtask

    // Count edges until done, bounded so a missing done still terminates.
    task automatic waitDone(output int cycles);
        cycles = 0;
        while (cycles < 40) begin
            @(posedge clk);
            #2;
            cycles++;
            if (bus.done === 1'b1) break;
        end
    endtask

    task automatic countDones(input int n, output int dones);
        dones = 0;
        repeat (n) begin
            @(posedge clk);
            #2;
            if (bus.done === 1'b1) dones++;
        end
    endtask

    initial begin
        int  cycles;
        int  dones;
        bit  sawDone;
        bus.start = 1'b0; bus.op = 1'b0; bus.sign_op = 1'b0;
        bus.rs_val = '0; bus.rt_val = '0; bus.hilo_rd = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_hi",    64'(bus.hi), 64'h0);
        checkOutput("reset_lo",    64'(bus.lo), 64'h0);
        checkOutput("reset_busy",  64'(bus.busy), 64'h0);
        checkOutput("reset_stall", 64'(bus.stall), 64'h0);
        checkOutput("reset_done",  64'(bus.done), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        bus.hilo_rd = 1'b0;
        checkEn = 1'b1;

        applyStimulus(1'b0, 1'b0, 32'd7, 32'd6, 1'b0, 1'b0);
        waitDone(cycles);
        checkOutput("mul_latency", 64'(cycles), 64'd32);
        checkOutput("mul_hi", 64'(bus.hi), 64'h0);
        checkOutput("mul_lo", 64'(bus.lo), 64'h2A);
        checkOutput("mul_dbz", 64'(bus.div_by_zero), 64'h0);

        applyStimulus(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        waitDone(cycles);
        checkOutput("multu_hi", 64'(bus.hi), 64'hFFFF_FFFE);
        checkOutput("multu_lo", 64'(bus.lo), 64'h0000_0001);

        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFA, 32'd7, 1'b0, 1'b0);
        waitDone(cycles);
`ifdef MULDIV_SIGNED_EN
        checkOutput("smul_latency", 64'(cycles), 64'd33);
        checkOutput("smul_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        checkOutput("smul_lo", 64'(bus.lo), 64'hFFFF_FFD6);
`else
        checkOutput("smul_latency", 64'(cycles), 64'd32);
        checkOutput("smul_hi", 64'(bus.hi), 64'h0000_0006);
        checkOutput("smul_lo", 64'(bus.lo), 64'hFFFF_FFD6);
`endif

        applyStimulus(1'b1, 1'b0, 32'd100, 32'd7, 1'b1, 1'b0);
        waitDone(cycles);
        checkOutput("div_latency", 64'(cycles), 64'd32);
        checkOutput("div_hi", 64'(bus.hi), 64'd2);
        checkOutput("div_lo", 64'(bus.lo), 64'd14);
        checkOutput("div_dbz", 64'(bus.div_by_zero), 64'h0);

        applyStimulus(1'b1, 1'b0, 32'd5, 32'd0, 1'b0, 1'b0);
        waitDone(cycles);
        checkOutput("dz_latency", 64'(cycles), 64'd32);
        checkOutput("dz_hi", 64'(bus.hi), 64'd5);
        checkOutput("dz_lo", 64'(bus.lo), 64'hFFFF_FFFF);
        checkOutput("dz_dbz", 64'(bus.div_by_zero), 64'h1);

`ifdef MULDIV_SIGNED_EN
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        waitDone(cycles);
        checkOutput("sdiv_latency", 64'(cycles), 64'd33);
        checkOutput("sdiv_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        checkOutput("sdiv_lo", 64'(bus.lo), 64'hFFFF_FFFD);
`endif

        // mfhi/mflo held from the third cycle of a mult.
        applyStimulus(1'b0, 1'b0, 32'd3, 32'd5, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        bus.hilo_rd = 1'b1;
        cycles = 0;
        sawDone = 1'b0;
        while (cycles < 40 && !sawDone) begin
            @(posedge clk);
            #2;
            cycles++;
            if (bus.done === 1'b1) begin
                sawDone = 1'b1;
                checkOutput("rd_stall_done", 64'(bus.stall), 64'h0);
            end else begin
                checkOutput("rd_stall_busy", 64'(bus.stall), 64'h1);
            end
        end
        checkOutput("rd_done_seen", 64'(sawDone), 64'h1);
        checkOutput("rd_latency", 64'(cycles), 64'd30);
        checkOutput("rd_lo", 64'(bus.lo), 64'd15);
        @(negedge clk);
        bus.hilo_rd = 1'b0;

        // div start sampled at cycle 10 of a mult must be ignored.
        applyStimulus(1'b0, 1'b0, 32'd9, 32'd11, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'd100, 32'd7, 1'b0, 1'b1);
        waitDone(cycles);
        checkOutput("ign_latency", 64'(cycles), 64'd22);
        checkOutput("ign_hi", 64'(bus.hi), 64'h0);
        checkOutput("ign_lo", 64'(bus.lo), 64'd99);
        countDones(40, dones);
        checkOutput("ign_no_done", 64'(dones), 64'd0);
        checkOutput("ign_idle", 64'(bus.busy), 64'h0);

        // Reset asserted at cycle 15 of a mult aborts it.
        applyStimulus(1'b0, 1'b0, 32'h1234, 32'h10, 1'b0, 1'b0);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        checkOutput("abort_busy", 64'(bus.busy), 64'h0);
        checkOutput("abort_hi", 64'(bus.hi), 64'h0);
        checkOutput("abort_lo", 64'(bus.lo), 64'h0);
        checkOutput("abort_done", 64'(bus.done), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        countDones(40, dones);
        checkOutput("abort_no_done", 64'(dones), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end
endmodule
